// File: rtl/accuracy_monitor.sv
// On-chip scoreboard for NeuralNetwork results: fetches each expected label
// from an external ROM, compares it with the reported class and keeps totals.
module accuracy_monitor #(
    parameter int N_SAMPLES = 750,
    parameter int LABEL_W   = 8,
    parameter int CNT_W     = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LABEL_W-1:0] result,
    input  logic               batch_done,
    input  logic               done,
    output logic               label_rd,
    output logic [CNT_W-1:0]   label_addr,
    input  logic [LABEL_W-1:0] label_data,
    output logic [CNT_W-1:0]   total_count,
    output logic [CNT_W-1:0]   correct_count,
    output logic               match_valid,
    output logic               match,
    output logic               finished,
    output logic               err_overrun,
    output logic               err_extra,
    output logic               err_short
);

    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_FETCH,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 bd_q;
    logic [LABEL_W-1:0]   res_q, res_d;
    logic                 label_rd_q, label_rd_d;
    logic [CNT_W-1:0]     label_addr_q, label_addr_d;
    logic [CNT_W-1:0]     total_q, total_d;
    logic [CNT_W-1:0]     correct_q, correct_d;
    logic                 match_valid_q, match_valid_d;
    logic                 match_q, match_d;
    logic                 finished_q, finished_d;
    logic                 err_overrun_q, err_overrun_d;
    logic                 err_extra_q, err_extra_d;
    logic                 err_short_q, err_short_d;
    logic                 done_flag_q, done_flag_d;

    logic                 bd_rise;
    logic [LABEL_W-1:0]   bit_eq;
    logic                 label_eq;
    logic [CNT_W-1:0]     total_inc;
    logic [CNT_W-1:0]     correct_inc;

    assign bd_rise = batch_done & ~bd_q;

    // Bitwise equality of the fetched label against the latched result.
    for (genvar gi = 0; gi < LABEL_W; gi++) begin : g_eq
        assign bit_eq[gi] = ~(label_data[gi] ^ res_q[gi]);
    end
    assign label_eq = &bit_eq;

    // Saturating increments so the counters can never pass N_SAMPLES.
    always_comb begin
        total_inc   = total_q;
        correct_inc = correct_q;
        if (total_q < N_CNT) begin
            total_inc = total_q + CNT_ONE;
            if (label_eq) begin
                correct_inc = correct_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        res_d         = res_q;
        label_rd_d    = 1'b0;
        label_addr_d  = label_addr_q;
        total_d       = total_q;
        correct_d     = correct_q;
        match_valid_d = 1'b0;
        match_d       = match_q;
        finished_d    = finished_q;
        err_overrun_d = err_overrun_q;
        err_extra_d   = err_extra_q;
        err_short_d   = err_short_q;
        done_flag_d   = done_flag_q;

        if (start) begin
            // A new run wins over everything; any in-flight compare is dropped.
            state_d       = S_ARMED;
            label_addr_d  = '0;
            total_d       = '0;
            correct_d     = '0;
            match_d       = 1'b0;
            finished_d    = 1'b0;
            err_overrun_d = 1'b0;
            err_extra_d   = 1'b0;
            err_short_d   = 1'b0;
            done_flag_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_ARMED: begin
                    if (bd_rise) begin
                        res_d        = result;
                        label_rd_d   = 1'b1;
                        label_addr_d = total_q;
                        done_flag_d  = done;
                        state_d      = S_FETCH;
                    end else if (done) begin
                        finished_d = 1'b1;
                        if (total_q < N_CNT) begin
                            err_short_d = 1'b1;
                        end
                        state_d = S_DONE;
                    end
                end
                S_FETCH: begin
                    if (bd_rise) begin
                        err_overrun_d = 1'b1;
                    end
                    if (done) begin
                        done_flag_d = 1'b1;
                    end
                    state_d = S_COMPARE;
                end
                S_COMPARE: begin
                    if (bd_rise) begin
                        err_overrun_d = 1'b1;
                    end
                    match_d       = label_eq;
                    match_valid_d = 1'b1;
                    total_d       = total_inc;
                    correct_d     = correct_inc;
                    done_flag_d   = 1'b0;
                    if (total_inc == N_CNT) begin
                        finished_d = 1'b1;
                        state_d    = S_DONE;
                    end else if (done_flag_q || done) begin
                        // Network ended early: finish the run short.
                        finished_d  = 1'b1;
                        err_short_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        state_d = S_ARMED;
                    end
                end
                S_DONE: begin
                    finished_d = 1'b1;
                    if (bd_rise) begin
                        err_extra_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            bd_q          <= 1'b0;
            res_q         <= '0;
            label_rd_q    <= 1'b0;
            label_addr_q  <= '0;
            total_q       <= '0;
            correct_q     <= '0;
            match_valid_q <= 1'b0;
            match_q       <= 1'b0;
            finished_q    <= 1'b0;
            err_overrun_q <= 1'b0;
            err_extra_q   <= 1'b0;
            err_short_q   <= 1'b0;
            done_flag_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bd_q          <= batch_done;
            res_q         <= res_d;
            label_rd_q    <= label_rd_d;
            label_addr_q  <= label_addr_d;
            total_q       <= total_d;
            correct_q     <= correct_d;
            match_valid_q <= match_valid_d;
            match_q       <= match_d;
            finished_q    <= finished_d;
            err_overrun_q <= err_overrun_d;
            err_extra_q   <= err_extra_d;
            err_short_q   <= err_short_d;
            done_flag_q   <= done_flag_d;
        end
    end

    assign label_rd      = label_rd_q;
    assign label_addr    = label_addr_q;
    assign total_count   = total_q;
    assign correct_count = correct_q;
    assign match_valid   = match_valid_q;
    assign match         = match_q;
    assign finished      = finished_q;
    assign err_overrun   = err_overrun_q;
    assign err_extra     = err_extra_q;
    assign err_short     = err_short_q;

endmodule

// File: tb/tb_accuracy_monitor.sv
// Directed bench for accuracy_monitor with a four-sample run and a
// registered label ROM model.
module tb_accuracy_monitor;

    localparam int N  = 4;
    localparam int LW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] result = '0;
    logic          batch_done = 1'b0;
    logic          done = 1'b0;
    logic          label_rd;
    logic [CW-1:0] label_addr;
    logic [LW-1:0] label_data = '0;
    logic [CW-1:0] total_count;
    logic [CW-1:0] correct_count;
    logic          match_valid;
    logic          match;
    logic          finished;
    logic          err_overrun;
    logic          err_extra;
    logic          err_short;

    logic [LW-1:0] rom [0:15];
    int n_cmp = 0;
    int n_bad = 0;

    accuracy_monitor #(.N_SAMPLES(N), .LABEL_W(LW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .result(result),
        .batch_done(batch_done), .done(done), .label_rd(label_rd),
        .label_addr(label_addr), .label_data(label_data),
        .total_count(total_count), .correct_count(correct_count),
        .match_valid(match_valid), .match(match), .finished(finished),
        .err_overrun(err_overrun), .err_extra(err_extra), .err_short(err_short)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (label_rd) label_data <= rom[label_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns just after the edge that samples the rise (state FETCH).
    task automatic pulse_bd(input logic [LW-1:0] r);
        result = r;
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] all_out;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        all_out = {label_rd, label_addr, total_count, correct_count, match_valid,
                   match, finished, err_overrun, err_extra, err_short};
        n_cmp++;
        if (all_out !== 19'd0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        pulse_bd(8'h01);
        n_cmp++;
        if (label_rd !== 1'b0) begin
            n_bad++; $display("FAIL idle_ignores_bd: label_rd got %b want 0", label_rd);
        end
        tick(); tick();
        n_cmp++;
        if (total_count !== 4'd0) begin
            n_bad++; $display("FAIL idle_total: got %0d want 0", total_count);
        end
        $display("reset: outputs checked, idle rise ignored");
    endtask

    task automatic test_single();
        rom[0] = 8'h03;
        do_start();
        pulse_bd(8'h03);
        n_cmp++;
        if ({label_rd, label_addr} !== {1'b1, 4'd0}) begin
            n_bad++; $display("FAIL single_fetch: rd/addr got %b/%0d want 1/0", label_rd, label_addr);
        end
        tick();
        n_cmp++;
        if (label_rd !== 1'b0) begin
            n_bad++; $display("FAIL single_rd_len: got %b want 0", label_rd);
        end
        tick();
        n_cmp++;
        if ({total_count, correct_count, match, match_valid} !== {4'd1, 4'd1, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL single_result: tot %0d cor %0d m %b mv %b want 1 1 1 1",
                              total_count, correct_count, match, match_valid);
        end
        tick();
        n_cmp++;
        if (match_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_mv_pulse: got %b want 0", match_valid);
        end
        $display("single: result 03 vs label 03, total %0d correct %0d", total_count, correct_count);
    endtask

    task automatic test_full_run();
        logic [LW-1:0] res_tab [0:3];
        logic          exp_m   [0:3];
        res_tab[0] = 8'd1; res_tab[1] = 8'd9; res_tab[2] = 8'd3; res_tab[3] = 8'd4;
        exp_m[0] = 1'b1; exp_m[1] = 1'b0; exp_m[2] = 1'b1; exp_m[3] = 1'b1;
        rom[0] = 8'd1; rom[1] = 8'd2; rom[2] = 8'd3; rom[3] = 8'd4;
        do_start();
        for (int i = 0; i < 4; i++) begin
            pulse_bd(res_tab[i]);
            tick(); tick();
            n_cmp++;
            if ({match_valid, match} !== {1'b1, exp_m[i]}) begin
                n_bad++; $display("FAIL full_match%0d: mv/m got %b/%b want 1/%b",
                                  i, match_valid, match, exp_m[i]);
            end
            $display("full: sample %0d result %0d match %b total %0d", i, res_tab[i], match, total_count);
        end
        n_cmp++;
        if ({total_count, correct_count, finished} !== {4'd4, 4'd3, 1'b1}) begin
            n_bad++; $display("FAIL full_end: tot %0d cor %0d fin %b want 4 3 1",
                              total_count, correct_count, finished);
        end
        pulse_bd(8'd5);
        tick(); tick();
        n_cmp++;
        if ({err_extra, total_count, correct_count, finished} !== {1'b1, 4'd4, 4'd3, 1'b1}) begin
            n_bad++; $display("FAIL full_extra: ext %b tot %0d cor %0d fin %b want 1 4 3 1",
                              err_extra, total_count, correct_count, finished);
        end
        $display("full: extra rise -> err_extra %b", err_extra);
    endtask

    task automatic test_overrun();
        rom[0] = 8'd7; rom[1] = 8'd8;
        do_start();
        pulse_bd(8'd7);
        tick();
        result = 8'hAA;
        batch_done = 1'b1;
        tick();
        batch_done = 1'b0;
        n_cmp++;
        if ({err_overrun, total_count, correct_count} !== {1'b1, 4'd1, 4'd1}) begin
            n_bad++; $display("FAIL ovr_flag: ovr %b tot %0d cor %0d want 1 1 1",
                              err_overrun, total_count, correct_count);
        end
        tick(); tick();
        n_cmp++;
        if (total_count !== 4'd1) begin
            n_bad++; $display("FAIL ovr_dropped: tot %0d want 1", total_count);
        end
        pulse_bd(8'd8);
        n_cmp++;
        if ({label_rd, label_addr} !== {1'b1, 4'd1}) begin
            n_bad++; $display("FAIL ovr_next_addr: rd/addr %b/%0d want 1/1", label_rd, label_addr);
        end
        tick(); tick();
        n_cmp++;
        if ({total_count, correct_count, match_valid, match} !== {4'd2, 4'd2, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL ovr_continue: tot %0d cor %0d mv %b m %b want 2 2 1 1",
                              total_count, correct_count, match_valid, match);
        end
        $display("overrun: err_overrun %b total %0d", err_overrun, total_count);
    endtask

    task automatic test_short_armed();
        rom[0] = 8'd1; rom[1] = 8'd2;
        do_start();
        for (int i = 0; i < 2; i++) begin
            pulse_bd(rom[i]);
            tick(); tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if ({finished, err_short, total_count} !== {1'b1, 1'b1, 4'd2}) begin
            n_bad++; $display("FAIL short_armed: fin %b short %b tot %0d want 1 1 2",
                              finished, err_short, total_count);
        end
        $display("short_armed: finished %b err_short %b total %0d", finished, err_short, total_count);
    endtask

    task automatic test_short_compare();
        rom[0] = 8'd1; rom[1] = 8'd2;
        do_start();
        pulse_bd(8'd1);
        tick(); tick();
        pulse_bd(8'd2);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_cmp++;
        if ({match_valid, total_count, finished, err_short} !== {1'b1, 4'd2, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL short_compare: mv %b tot %0d fin %b short %b want 1 2 1 1",
                              match_valid, total_count, finished, err_short);
        end
        $display("short_compare: total %0d finished %b", total_count, finished);
    endtask

    task automatic test_hold();
        int mv_seen;
        mv_seen = 0;
        rom[0] = 8'h42;
        do_start();
        result = 8'h42;
        batch_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (match_valid) mv_seen++;
        end
        batch_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (match_valid) mv_seen++;
        end
        n_cmp++;
        if ({total_count, err_overrun} !== {4'd1, 1'b0} || mv_seen != 1) begin
            n_bad++; $display("FAIL hold_one: tot %0d ovr %b mv_pulses %0d want 1 0 1",
                              total_count, err_overrun, mv_seen);
        end
        $display("hold: total %0d match_valid pulses %0d", total_count, mv_seen);
    endtask

    task automatic test_start_mid();
        rom[0] = 8'd5; rom[1] = 8'd6;
        do_start();
        pulse_bd(8'd5);
        tick(); tick();
        pulse_bd(8'd6);
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({total_count, correct_count, match_valid, err_overrun, err_extra, err_short, finished}
            !== 13'd0) begin
            n_bad++; $display("FAIL start_mid_clear: tot %0d cor %0d mv %b errs %b%b%b fin %b want 0",
                              total_count, correct_count, match_valid, err_overrun, err_extra,
                              err_short, finished);
        end
        tick();
        n_cmp++;
        if ({match_valid, total_count} !== {1'b0, 4'd0}) begin
            n_bad++; $display("FAIL start_mid_nomv: mv %b tot %0d want 0 0", match_valid, total_count);
        end
        pulse_bd(8'd5);
        n_cmp++;
        if ({label_rd, label_addr} !== {1'b1, 4'd0}) begin
            n_bad++; $display("FAIL start_mid_addr: rd/addr %b/%0d want 1/0", label_rd, label_addr);
        end
        tick(); tick();
        n_cmp++;
        if ({total_count, correct_count, match} !== {4'd1, 4'd1, 1'b1}) begin
            n_bad++; $display("FAIL start_mid_next: tot %0d cor %0d m %b want 1 1 1",
                              total_count, correct_count, match);
        end
        $display("start_mid: restart total %0d correct %0d", total_count, correct_count);
    endtask

    task automatic test_rst_compare();
        logic [18:0] all_out;
        rom[0] = 8'd9;
        do_start();
        pulse_bd(8'd9);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        all_out = {label_rd, label_addr, total_count, correct_count, match_valid,
                   match, finished, err_overrun, err_extra, err_short};
        n_cmp++;
        if (all_out !== 19'd0) begin
            n_bad++; $display("FAIL rst_compare: got %h want 0", all_out);
        end
        pulse_bd(8'd9);
        tick(); tick();
        n_cmp++;
        if ({total_count, match_valid, label_rd} !== {4'd0, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL rst_ignore: tot %0d mv %b rd %b want 0 0 0",
                              total_count, match_valid, label_rd);
        end
        $display("rst_compare: outputs cleared, total %0d after ignored rise", total_count);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = '0;
        test_reset();
        test_single();
        test_full_run();
        test_overrun();
        test_short_armed();
        test_short_compare();
        test_hold();
        test_start_mid();
        test_rst_compare();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
